imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Sequences the byte-addressed, combinational-read instruction memory (32-bit little-endian instruction at bytes adr..adr+3) for the pipelined RISC-V core.
- LOAD mode: accepts a byte stream over a valid/ready handshake and drives the memory byte-write port.
- RUN mode: owns the PC, fetches one instruction per cycle into the IF/ID register, and honours stall, redirect (branch/jump) and end-of-program.
- Sits between the loader/debug host, the instruction memory and the decode stage.

Parameters:
- MEM_SIZE, 64, instruction memory depth in bytes.
- RESET_PC, 0, first fetch address after reset, load completion or run_start.
- INIT_LEN, 16, program length in bytes valid after reset (preinitialised image).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  enter LOAD (sampled in IDLE, RUN, HALT).
- run_start  in  1  enter RUN with the current prog_len (sampled in IDLE, HALT).
- ld_valid  in  1  ld_byte is valid.
- ld_byte  in  8  load data byte.
- ld_last  in  1  qualifies the final byte of the stream.
- ld_ready  out  1  controller accepts a byte.
- mem_we  out  1  memory byte write enable.
- mem_wadr  out  64  memory byte write address.
- mem_wdata  out  8  memory write byte.
- mem_adr  out  64  memory read address (always equals pc).
- mem_instr  in  32  memory read data, combinational from mem_adr.
- stall  in  1  hold PC and IF/ID register.
- redirect  in  1  branch/jump taken; flush.
- redirect_pc  in  64  redirect target.
- if_pc  out  64  PC of the instruction in IF/ID.
- if_instr  out  32  instruction in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction.
- running  out  1  state == RUN.
- prog_len  out  64  program length in bytes.
- err_misalign  out  1  sticky; redirect target not 4-byte aligned.
- err_overflow  out  1  sticky; load exceeded MEM_SIZE.

Behaviour:
- States: IDLE, LOAD, RUN, HALT.
- Reset:
  - State IDLE, pc = RESET_PC, prog_len = INIT_LEN.
  - if_pc = 0, if_instr = 0 (NOP encoding not required), if_valid = 0.
  - Load write pointer wptr = 0, both error flags 0.
  - A reset during LOAD abandons the stream; the partial prog_len is not kept.
- Transitions:
  - IDLE: load_start -> LOAD; else run_start -> RUN. load_start wins if both are high.
  - LOAD: the byte carrying ld_last is accepted -> RUN.
  - RUN: load_start -> LOAD; misaligned redirect -> HALT.
  - HALT: load_start -> LOAD; else run_start -> RUN.
  - Every entry to RUN or LOAD sets pc = RESET_PC and if_valid = 0.
  - Entry to LOAD also sets wptr = 0 and prog_len = 0.
- LOAD:
  - ld_ready = 1 in LOAD only.
  - mem_we = ld_valid, combinational; mem_wadr = wptr, mem_wdata = ld_byte.
  - Accepted byte (ld_valid & ld_ready): wptr += 1, prog_len = wptr + 1.
  - wptr >= MEM_SIZE: mem_we forced 0, byte dropped, err_overflow set, prog_len saturates at MEM_SIZE. The handshake still completes.
  - if_valid = 0 throughout LOAD.
- RUN, per cycle, in priority order:
  1. redirect:
     - redirect_pc[1:0] != 0: err_misalign set, if_valid <= 0, go to HALT, pc unchanged.
     - otherwise: pc <= redirect_pc, if_valid <= 0 (one-bubble flush). This applies even when stall is high.
  2. stall: pc, if_pc, if_instr and if_valid hold.
  3. End of program (pc + 4 > prog_len): if_valid <= 0 and pc holds. A later redirect can still resume fetch.
  4. Otherwise: if_pc <= pc, if_instr <= mem_instr, if_valid <= 1, pc <= pc + 4.
- Latency: the instruction at pc is visible on if_instr/if_valid on the cycle after the fetch edge.
- Arithmetic: pc arithmetic is 64-bit wrap-around. The end-of-program compare is done in 65 bits so pc near 2^64 cannot alias.
- HALT:
  - if_valid = 0, pc frozen.
  - Error flags persist until reset, or until the next LOAD entry (clears err_overflow only).
- running = (state == RUN).

Test Plan:
1. Reset, run_start with INIT_LEN = 16 and memory bytes B3 00 21 00 | 23 26 10 00 | 83 21 C0 00 | E3 0A 31 FE -> if_instr sequence 0x002100B3, 0x00102623, 0x00C02183, 0xFE310AE3 with if_pc 0, 4, 8, 12 on consecutive cycles; then if_valid = 0 and pc stays 16.
2. load_start, then 8 bytes 13 00 00 00 93 00 10 00 with ld_last on the 8th, ld_valid toggling every other cycle -> 8 writes at mem_wadr 0..7, prog_len = 8, RUN next cycle; if_instr = 0x00000013 then 0x00100093.
3. In RUN at pc = 8: stall high for 3 cycles -> if_pc/if_instr unchanged; redirect to 0x4 asserted together with stall -> next cycle if_valid = 0, the following cycle if_pc = 4.
4. Redirect to 0x6 -> err_misalign = 1, running = 0, if_valid = 0. run_start -> fetch resumes at RESET_PC, err_misalign still 1.
5. With MEM_SIZE = 64, load 66 bytes -> mem_we low for bytes 65 and 66, err_overflow = 1, prog_len = 64, RUN entered after ld_last.
6. Reset asserted mid-load after 5 bytes -> next cycle IDLE, ld_ready = 0, prog_len = INIT_LEN, wptr = 0, if_valid = 0.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Loader byte stream and instruction-memory port bundle for imem_fetch_ctrl.
// master = fetch controller, slave = loader host plus memory.
interface imem_fetch_ctrl_if;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        mem_we;
    logic [63:0] mem_wadr;
    logic [7:0]  mem_wdata;
    logic [63:0] mem_adr;
    logic [31:0] mem_instr;

    modport master (
        input  ld_valid, ld_byte, ld_last, mem_instr,
        output ld_ready, mem_we, mem_wadr, mem_wdata, mem_adr
    );

    modport slave (
        output ld_valid, ld_byte, ld_last, mem_instr,
        input  ld_ready, mem_we, mem_wadr, mem_wdata, mem_adr
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: byte-stream program loader plus the PC and
// IF/ID register of the pipelined core's fetch stage.
module imem_fetch_ctrl #(
    parameter int unsigned MEM_SIZE = 64,
    parameter logic [63:0] RESET_PC = '0,
    parameter int unsigned INIT_LEN = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               run_start,
    imem_fetch_ctrl_if.master  bus,
    input  logic               stall,
    input  logic               redirect,
    input  logic [63:0]        redirect_pc,
    output logic [63:0]        if_pc,
    output logic [31:0]        if_instr,
    output logic               if_valid,
    output logic               running,
    output logic [63:0]        prog_len,
    output logic               err_misalign,
    output logic               err_overflow
);
    localparam logic [63:0] MEM_SIZE_W = 64'(MEM_SIZE);
    localparam logic [63:0] INIT_LEN_W = 64'(INIT_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] prog_len_q, prog_len_d;
    logic [63:0] wptr_q, wptr_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        err_mis_q, err_mis_d;
    logic        err_ovf_q, err_ovf_d;

    logic        go_load, go_run;
    logic        wr_ok;
    logic [64:0] fetch_end;

    assign wr_ok         = (wptr_q < MEM_SIZE_W);
    assign bus.ld_ready  = (state_q == LOAD);
    assign bus.mem_we    = (state_q == LOAD) && bus.ld_valid && wr_ok;
    assign bus.mem_wadr  = wptr_q;
    assign bus.mem_wdata = bus.ld_byte;
    assign bus.mem_adr   = pc_q;

    assign if_pc        = if_pc_q;
    assign if_instr     = if_instr_q;
    assign if_valid     = if_valid_q;
    assign running      = (state_q == RUN);
    assign prog_len     = prog_len_q;
    assign err_misalign = err_mis_q;
    assign err_overflow = err_ovf_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        prog_len_d = prog_len_q;
        wptr_d     = wptr_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        err_mis_d  = err_mis_q;
        err_ovf_d  = err_ovf_q;
        go_load    = 1'b0;
        go_run     = 1'b0;
        // 65-bit end compare so a pc near 2^64 cannot wrap below prog_len
        fetch_end  = {1'b0, pc_q} + 65'd4;

        case (state_q)
            IDLE, HALT: begin
                if_valid_d = 1'b0;
                if (load_start) begin
                    go_load = 1'b1;
                end else if (run_start) begin
                    go_run = 1'b1;
                end
            end
            LOAD: begin
                if_valid_d = 1'b0;
                if (bus.ld_valid) begin
                    if (wr_ok) begin
                        wptr_d     = wptr_q + 64'd1;
                        prog_len_d = wptr_q + 64'd1;
                    end else begin
                        err_ovf_d  = 1'b1;
                        prog_len_d = MEM_SIZE_W;
                    end
                    if (bus.ld_last) begin
                        go_run = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_start) begin
                    go_load = 1'b1;
                end else if (redirect) begin
                    if_valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        err_mis_d = 1'b1;
                        state_d   = HALT;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (stall) begin
                    if_valid_d = if_valid_q;
                end else if (fetch_end > {1'b0, prog_len_q}) begin
                    if_valid_d = 1'b0;
                end else begin
                    if_pc_d    = pc_q;
                    if_instr_d = bus.mem_instr;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 64'd4;
                end
            end
            default: state_d = IDLE;
        endcase

        // Mode entry overrides whatever the per-state logic decided above
        if (go_load) begin
            state_d    = LOAD;
            pc_d       = RESET_PC;
            if_valid_d = 1'b0;
            wptr_d     = '0;
            prog_len_d = '0;
            err_ovf_d  = 1'b0;
        end
        if (go_run) begin
            state_d    = RUN;
            pc_d       = RESET_PC;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            prog_len_q <= INIT_LEN_W;
            wptr_q     <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            err_mis_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            prog_len_q <= prog_len_d;
            wptr_q     <= wptr_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            err_mis_q  <= err_mis_d;
            err_ovf_q  <= err_ovf_d;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a 64-byte memory model whose image
// is reloaded while reset is high.
module tb_imem_fetch_ctrl;
    localparam logic [127:0] IMG = 128'hFE310AE3_00C02183_00102623_002100B3;
    localparam logic [63:0]  LD2 = 64'h00100093_00000013;

    logic        clk = 1'b0;
    logic        reset, load_start, run_start, stall, redirect;
    logic [63:0] redirect_pc;
    logic [63:0] if_pc, prog_len;
    logic [31:0] if_instr;
    logic        if_valid, running, err_misalign, err_overflow;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [7:0] mem [64];
    logic [5:0] ra;

    imem_fetch_ctrl_if bus();

    imem_fetch_ctrl #(.MEM_SIZE(64), .RESET_PC(64'd0), .INIT_LEN(16)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .run_start(run_start),
        .bus(bus), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .running(running),
        .prog_len(prog_len), .err_misalign(err_misalign), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= (i < 16) ? IMG[8*i +: 8] : 8'h00;
        end else if (bus.mem_we) begin
            mem[bus.mem_wadr[5:0]] <= bus.mem_wdata;
        end
    end

    always_comb begin
        ra = bus.mem_adr[5:0];
        bus.mem_instr = {mem[ra + 6'd3], mem[ra + 6'd2], mem[ra + 6'd1], mem[ra]};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; load_start = 1'b0; run_start = 1'b0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0;
        bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_last = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_running", running, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_instr", if_instr, 0);
        chk("rst_prog_len", prog_len, 16);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_errs", {err_misalign, err_overflow}, 0);

        // 1: run the preinitialised image
        run_start = 1'b1; step(); run_start = 1'b0;
        chk("t1_running", running, 1);
        chk("t1_bubble", if_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_if_valid", if_valid, 1);
            chk("t1_if_pc", if_pc, 64'(4 * i));
            chk("t1_if_instr", if_instr, IMG[32*i +: 32]);
        end
        step();
        chk("t1_end_valid", if_valid, 0);
        chk("t1_end_pc", bus.mem_adr, 16);
        step();
        chk("t1_end_hold", bus.mem_adr, 16);

        // 2: load 8 bytes with ld_valid toggling
        load_start = 1'b1; step(); load_start = 1'b0;
        chk("t2_ld_ready", bus.ld_ready, 1);
        chk("t2_prog_len0", prog_len, 0);
        chk("t2_running", running, 0);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            bus.ld_valid = i[0];
            bus.ld_byte  = i[0] ? LD2[8*k +: 8] : 8'hAA;
            bus.ld_last  = i[0] && (k == 7);
            #1;
            chk("t2_mem_we", bus.mem_we, i[0]);
            if (i[0]) begin
                chk("t2_mem_wadr", bus.mem_wadr, 64'(k));
                k++;
            end
            step();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("t2_run", running, 1);
        chk("t2_prog_len", prog_len, 8);
        chk("t2_ld_ready_off", bus.ld_ready, 0);
        step();
        chk("t2_instr0", if_instr, 32'h00000013);
        chk("t2_pc0", if_pc, 0);
        step();
        chk("t2_instr1", if_instr, 32'h00100093);
        chk("t2_pc1", if_pc, 4);
        chk("t2_valid1", if_valid, 1);

        // 3: stall at pc 8, redirect under stall, then stall while valid
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall_pc", if_pc, 4);
            chk("t3_stall_instr", if_instr, 32'h00100093);
            chk("t3_stall_adr", bus.mem_adr, 8);
        end
        redirect = 1'b1; redirect_pc = 64'h4; step(); redirect = 1'b0; stall = 1'b0;
        chk("t3_flush_valid", if_valid, 0);
        chk("t3_redir_adr", bus.mem_adr, 4);
        step();
        chk("t3_redir_if_pc", if_pc, 4);
        chk("t3_redir_valid", if_valid, 1);
        redirect = 1'b1; redirect_pc = 64'h0; step(); redirect = 1'b0;
        step();
        chk("t3_r0_if_pc", if_pc, 0);
        stall = 1'b1; step(); step(); stall = 1'b0;
        chk("t3_stall_valid", if_valid, 1);
        chk("t3_stall_if_pc", if_pc, 0);
        chk("t3_stall_pc_hold", bus.mem_adr, 4);

        // 4: misaligned redirect halts; run_start resumes at RESET_PC
        redirect = 1'b1; redirect_pc = 64'h6; step(); redirect = 1'b0;
        chk("t4_err_mis", err_misalign, 1);
        chk("t4_running", running, 0);
        chk("t4_valid", if_valid, 0);
        chk("t4_pc_frozen", bus.mem_adr, 4);
        step();
        chk("t4_halt_hold", bus.mem_adr, 4);
        run_start = 1'b1; step(); run_start = 1'b0;
        chk("t4_resume_run", running, 1);
        chk("t4_resume_adr", bus.mem_adr, 0);
        step();
        chk("t4_resume_instr", if_instr, 32'h00000013);
        chk("t4_err_sticky", err_misalign, 1);

        // 5: overflow load of 66 bytes
        load_start = 1'b1; step(); load_start = 1'b0;
        chk("t5_mis_kept", err_misalign, 1);
        for (int i = 0; i < 66; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_byte  = 8'(i + 8'h40);
            bus.ld_last  = (i == 65);
            #1;
            chk("t5_mem_we", bus.mem_we, (i < 64) ? 1 : 0);
            step();
        end
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        chk("t5_err_ovf", err_overflow, 1);
        chk("t5_prog_len", prog_len, 64);
        chk("t5_run", running, 1);
        step();
        chk("t5_instr", if_instr, 32'h43424140);

        // 6: reset in the middle of a load
        load_start = 1'b1; step(); load_start = 1'b0;
        chk("t6_ovf_clr", err_overflow, 0);
        for (int i = 0; i < 5; i++) begin
            bus.ld_valid = 1'b1; bus.ld_byte = 8'(i); step();
        end
        bus.ld_valid = 1'b0;
        chk("t6_partial_len", prog_len, 5);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_running", running, 0);
        chk("t6_ld_ready", bus.ld_ready, 0);
        chk("t6_prog_len", prog_len, 16);
        chk("t6_wptr", bus.mem_wadr, 0);
        chk("t6_valid", if_valid, 0);
        chk("t6_errs", {err_misalign, err_overflow}, 0);

        // load_start beats run_start in IDLE
        load_start = 1'b1; run_start = 1'b1; step(); load_start = 1'b0; run_start = 1'b0;
        chk("idle_prio_ld", bus.ld_ready, 1);
        chk("idle_prio_run", running, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
